// File: rtl/mips_avalon_pkg.sv
// Shared types and constants for the MIPS instruction/data to Avalon-MM arbiter.
package mips_avalon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/mips_avalon_arbiter.sv
// Arbitrates a MIPS instruction port and data port onto one Avalon-MM master,
// with round-robin or fixed data priority and a waitrequest watchdog.
module mips_avalon_arbiter
  import mips_avalon_pkg::*;
#(
  parameter int unsigned RR_MODE        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  // instruction port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  // data port
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  // Avalon-MM master
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  req_id_e         last_q;
  logic [CntW-1:0] wait_cnt_q;
  logic            pick_data;

  // On a tie, round-robin serves whoever was not granted last.
  always_comb begin
    pick_data = d_req && (!i_req || (RR_MODE == 0) || (last_q == REQ_INSTR));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      last_q         <= REQ_DATA;
      wait_cnt_q     <= '0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= 4'b0000;
      i_ack          <= 1'b0;
      d_ack          <= 1'b0;
      i_rdata        <= '0;
      d_rdata        <= '0;
      timeout_err    <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state_q)
        IDLE: begin
          wait_cnt_q <= '0;
          if (pick_data) begin
            last_q         <= REQ_DATA;
            avm_address    <= d_addr;
            avm_writedata  <= d_wdata;
            avm_byteenable <= d_byteenable;
            avm_read       <= ~d_write;
            avm_write      <= d_write;
            state_q        <= BUS_D;
          end else if (i_req) begin
            last_q         <= REQ_INSTR;
            avm_address    <= i_addr;
            avm_byteenable <= BE_ALL;
            avm_read       <= 1'b1;
            avm_write      <= 1'b0;
            state_q        <= BUS_I;
          end
        end
        BUS_I, BUS_D: begin
          if (!avm_waitrequest) begin
            avm_read   <= 1'b0;
            avm_write  <= 1'b0;
            wait_cnt_q <= '0;
            if (state_q == BUS_I) begin
              i_rdata <= avm_readdata;
              i_ack   <= 1'b1;
            end else begin
              // A completed write leaves the last read word in place.
              if (!avm_write) d_rdata <= avm_readdata;
              d_ack <= 1'b1;
            end
            state_q <= RESP;
          end else if (wait_cnt_q == CntLast) begin
            avm_read    <= 1'b0;
            avm_write   <= 1'b0;
            wait_cnt_q  <= '0;
            timeout_err <= 1'b1;
            if (state_q == BUS_I) begin
              i_rdata <= '0;
              i_ack   <= 1'b1;
            end else begin
              d_rdata <= '0;
              d_ack   <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        RESP: begin
          // Ack is high for this single cycle; requester updates req at the exit edge.
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Scoreboard bench: stimulus pushes expected acks, a negedge monitor pops and compares.
module tb_mips_avalon_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        i_req, i_ack, d_req, d_write, d_ack;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_byteenable;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_waitrequest, timeout_err;
  logic [3:0]  avm_byteenable;

  // fixed-priority instance
  logic        f_i_req, f_i_ack, f_d_req, f_d_ack, f_timeout_err;
  logic [31:0] f_i_addr, f_i_rdata, f_d_addr, f_d_rdata;
  logic [31:0] f_avm_address, f_avm_writedata, f_avm_readdata;
  logic        f_avm_read, f_avm_write;
  logic [3:0]  f_avm_byteenable;
  logic        f_d_write = 1'b0;
  logic [31:0] f_d_wdata = 32'h0;
  logic [3:0]  f_d_be = 4'hF;
  logic        f_waitreq = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // RAM model: ws wait states per access, or stall forever
  logic [31:0] mem [0:63];
  bit          mem_init = 1'b0;
  int          ws = 0;
  bit          stall = 1'b0;
  int          bcnt = 0;

  assign avm_waitrequest = stall || ((avm_read || avm_write) && (bcnt < ws));
  assign avm_readdata    = mem[avm_address[7:2]];
  assign f_avm_readdata  = ~f_avm_address;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[1]   <= 32'h1234_5678;
      mem_init <= 1'b1;
    end else begin
      if (avm_read || avm_write) bcnt <= bcnt + 1;
      else bcnt <= 0;
      if (avm_write && !avm_waitrequest)
        for (int b = 0; b < 4; b++)
          if (avm_byteenable[b]) mem[avm_address[7:2]][8*b +: 8] <= avm_writedata[8*b +: 8];
    end
  end

  mips_avalon_arbiter #(.RR_MODE(1), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_ack(d_ack), .d_rdata(d_rdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .timeout_err(timeout_err)
  );

  mips_avalon_arbiter #(.RR_MODE(0), .TIMEOUT_CYCLES(8)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .i_req(f_i_req), .i_addr(f_i_addr), .i_ack(f_i_ack), .i_rdata(f_i_rdata),
    .d_req(f_d_req), .d_write(f_d_write), .d_addr(f_d_addr), .d_wdata(f_d_wdata),
    .d_byteenable(f_d_be), .d_ack(f_d_ack), .d_rdata(f_d_rdata),
    .avm_address(f_avm_address), .avm_read(f_avm_read), .avm_write(f_avm_write),
    .avm_writedata(f_avm_writedata), .avm_byteenable(f_avm_byteenable),
    .avm_waitrequest(f_waitreq), .avm_readdata(f_avm_readdata),
    .timeout_err(f_timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got no response expected response within bound", name);
  endtask

  always @(negedge clk) begin
    if (reset_n && (i_ack || d_ack)) begin
      chk("ack_onehot", 32'(i_ack & d_ack), 32'h0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got i_ack=%0b d_ack=%0b expected none", i_ack, d_ack);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_port", 32'(d_ack), 32'(mon_e.is_d));
        chk("ack_rdata", mon_e.is_d ? d_rdata : i_rdata, mon_e.rdata);
      end
    end
  end

  task automatic xfer(input bit is_d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] exp,
                      output int lat, output int bus, output logic [31:0] c_addr,
                      output logic [3:0] c_be, output logic [31:0] c_wdata, output bit c_wr);
    bit got = 1'b0;
    lat = 0; bus = 0; c_addr = '0; c_be = '0; c_wdata = '0; c_wr = 1'b0;
    sb.push_back('{is_d, exp});
    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1'b1; d_write = wr; d_addr = addr; d_wdata = wdata; d_byteenable = be;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (avm_read || avm_write) begin
        if (bus == 0) begin
          c_addr = avm_address; c_be = avm_byteenable; c_wdata = avm_writedata; c_wr = avm_write;
        end
        bus++;
      end
      if (is_d ? d_ack : i_ack) got = 1'b1;
    end
    if (!got) fail_now("xfer_ack_timeout");
    @(posedge clk); #1;
    if (is_d) d_req = 1'b0;
    else i_req = 1'b0;
  endtask

  task automatic wait_ack(input bit is_d, input string name);
    bit got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (is_d ? d_ack : i_ack) got = 1'b1;
    end
    if (!got) fail_now(name);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int          lat, bus, acks, n;
  logic [31:0] ca, cw;
  logic [3:0]  cb;
  bit          cwr, seen;
  logic [31:0] last_d;

  initial begin
    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_byteenable = '0;
    f_i_req = 1'b0; f_d_req = 1'b0; f_i_addr = 32'h40; f_d_addr = 32'h20;
    last_d = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_avm_read", 32'(avm_read), 32'h0);
    chk("rst_avm_write", 32'(avm_write), 32'h0);
    chk("rst_acks", 32'({i_ack, d_ack}), 32'h0);
    chk("rst_byteenable", 32'(avm_byteenable), 32'h0);
    chk("rst_timeout_err", 32'(timeout_err), 32'h0);
    chk("rst_address", avm_address, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // instruction read with two wait states
    ws = 2;
    xfer(1'b0, 1'b0, 32'hBFC0_0004, 32'h0, 4'hF, 32'h1234_5678, lat, bus, ca, cb, cw, cwr);
    chk("i_read_bus_cycles", 32'(bus), 32'd3);
    chk("i_read_addr", ca, 32'hBFC0_0004);
    chk("i_read_be", 32'(cb), 32'hF);
    chk("i_read_not_write", 32'(cwr), 32'h0);

    // data write then readback, zero wait states
    ws = 0;
    xfer(1'b1, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0011, last_d, lat, bus, ca, cb, cw, cwr);
    chk("d_write_latency", 32'(lat), 32'd3);
    chk("d_write_bus_cycles", 32'(bus), 32'd1);
    chk("d_write_dir", 32'(cwr), 32'h1);
    chk("d_write_be", 32'(cb), 32'h3);
    chk("d_write_wdata", cw, 32'hAABB_CCDD);
    chk("d_write_addr", ca, 32'h10);
    xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0000_CCDD, lat, bus, ca, cb, cw, cwr);
    last_d = 32'h0000_CCDD;
    chk("d_read_dir", 32'(cwr), 32'h0);
    chk("i_rdata_held", i_rdata, 32'h1234_5678);

    // tie from reset, round-robin: I, D, I, D
    pulse_reset();
    last_d = 32'h0;
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    sb.push_back('{1'b0, 32'h1234_5678});
    sb.push_back('{1'b1, 32'h0000_CCDD});
    sb.push_back('{1'b0, 32'h1234_5678});
    sb.push_back('{1'b1, 32'h0000_CCDD});
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'hBFC0_0004;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h10; d_byteenable = 4'hF;
    acks = 0;
    for (int k = 0; k < 100 && acks < 4; k++) begin
      @(negedge clk);
      if (i_ack || d_ack) acks++;
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    chk("rr_ack_count", 32'(acks), 32'd4);
    last_d = 32'h0000_CCDD;

    // tie on the fixed-priority instance: data first
    @(posedge clk); #1;
    f_i_req = 1'b1; f_d_req = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (f_i_ack || f_d_ack) seen = 1'b1;
    end
    if (!seen) fail_now("fp_first_ack");
    chk("fp_first_is_d", 32'({f_d_ack, f_i_ack}), 32'h2);
    chk("fp_d_rdata", f_d_rdata, 32'hFFFF_FFDF);
    @(posedge clk); #1;
    f_d_req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (f_i_ack || f_d_ack) seen = 1'b1;
    end
    if (!seen) fail_now("fp_second_ack");
    chk("fp_second_is_i", 32'({f_d_ack, f_i_ack}), 32'h1);
    chk("fp_i_rdata", f_i_rdata, 32'hFFFF_FFBF);
    @(posedge clk); #1;
    f_i_req = 1'b0;

    // stalled read aborts after 8 waitrequest cycles
    stall = 1'b1;
    xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0, lat, bus, ca, cb, cw, cwr);
    stall = 1'b0;
    last_d = 32'h0;
    chk("stall_bus_cycles", 32'(bus), 32'd8);
    chk("stall_timeout_err", 32'(timeout_err), 32'h1);
    xfer(1'b0, 1'b0, 32'hBFC0_0004, 32'h0, 4'hF, 32'h1234_5678, lat, bus, ca, cb, cw, cwr);
    chk("timeout_err_sticky", 32'(timeout_err), 32'h1);

    // reset during a stalled data write
    stall = 1'b1;
    @(posedge clk); #1;
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h20; d_wdata = 32'h5555_5555; d_byteenable = 4'hF;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (avm_write) seen = 1'b1;
    end
    if (!seen) fail_now("rst_mid_write_start");
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_avm_write", 32'(avm_write), 32'h0);
    chk("rst_mid_address", avm_address, 32'h0);
    chk("rst_mid_wdata", avm_writedata, 32'h0);
    chk("rst_mid_timeout_err", 32'(timeout_err), 32'h0);
    d_req = 1'b0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    last_d = 32'h0;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (d_ack) acks++;
    end
    chk("rst_mid_no_ack", 32'(acks), 32'h0);

    // back-to-back writes: next request presented at the ack edge
    ws = 0;
    sb.push_back('{1'b1, last_d});
    @(posedge clk); #1;
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h14; d_wdata = 32'h1111_1111; d_byteenable = 4'hF;
    wait_ack(1'b1, "b2b_first_ack");
    sb.push_back('{1'b1, last_d});
    @(posedge clk); #1;
    d_addr = 32'h18; d_wdata = 32'h2222_2222;
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      n++;
      if (avm_write) seen = 1'b1;
    end
    chk("b2b_gap", 32'(n), 32'd2);
    chk("b2b_addr", avm_address, 32'h18);
    wait_ack(1'b1, "b2b_second_ack");
    @(posedge clk); #1;
    d_req = 1'b0;
    xfer(1'b1, 1'b0, 32'h18, 32'h0, 4'hF, 32'h2222_2222, lat, bus, ca, cb, cw, cwr);
    xfer(1'b1, 1'b0, 32'h14, 32'h0, 4'hF, 32'h1111_1111, lat, bus, ca, cb, cw, cwr);

    repeat (5) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
